// File: rtl/axi_write_only_ctrl_if.sv
// AXI4 write-channel bundle (AW/W/B) for axi_write_only_ctrl.
// The master modport is the bus initiator; the slave modport is the controller.
interface axi_write_only_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 16,
  parameter int USER_W = 10
);
  localparam int NB = DATA_W / 8;

  logic [ID_W-1:0]   AWID;
  logic [ADDR_W-1:0] AWADDR;
  logic [7:0]        AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWLOCK;
  logic [3:0]        AWCACHE;
  logic [2:0]        AWPROT;
  logic [3:0]        AWREGION;
  logic [USER_W-1:0] AWUSER;
  logic [3:0]        AWQOS;
  logic              AWVALID;
  logic              AWREADY;

  logic [DATA_W-1:0] WDATA;
  logic [NB-1:0]     WSTRB;
  logic              WLAST;
  logic [USER_W-1:0] WUSER;
  logic              WVALID;
  logic              WREADY;

  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic [USER_W-1:0] BUSER;
  logic              BVALID;
  logic              BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT,
           AWREGION, AWUSER, AWQOS, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WUSER, WVALID,
    input  WREADY,
    input  BID, BRESP, BUSER, BVALID,
    output BREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT,
           AWREGION, AWUSER, AWQOS, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WUSER, WVALID,
    output WREADY,
    output BID, BRESP, BUSER, BVALID,
    input  BREADY
  );
endinterface

// File: rtl/axi_write_only_ctrl.sv
// AXI4 write-only slave: turns AW/W bursts into single-port SRAM writes,
// one transaction at a time, arbitrated through grant_i/valid_o.
// Optional protocol checking: define AXI_WRITE_ERR_CHECK_EN to report
// WLAST/AWLEN disagreement and WRAP bursts as SLVERR (data is still written).
module axi_write_only_ctrl #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_WDATA_WIDTH   = 64,
  parameter int AXI4_ID_WIDTH      = 16,
  parameter int AXI4_USER_WIDTH    = 10,
  parameter int AXI_NUMBYTES       = AXI4_WDATA_WIDTH / 8,
  parameter int MEM_ADDR_WIDTH     = 13
) (
  input  logic                          clk,
  input  logic                          rst,
  axi_write_only_ctrl_if.slave          axi,
  output logic                          MEM_CEN_o,
  output logic                          MEM_WEN_o,
  output logic [MEM_ADDR_WIDTH-1:0]     MEM_A_o,
  output logic [AXI4_WDATA_WIDTH-1:0]   MEM_D_o,
  output logic [AXI_NUMBYTES-1:0]       MEM_BE_o,
  input  logic [AXI4_WDATA_WIDTH-1:0]   MEM_Q_i,
  input  logic                          grant_i,
  output logic                          valid_o
);
  localparam int OFFSET_BIT = $clog2(AXI4_WDATA_WIDTH) - 3;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                      state_reg, state_next;
  logic [AXI4_ID_WIDTH-1:0]    id_reg, id_next;
  logic [AXI4_USER_WIDTH-1:0]  user_reg, user_next;
  logic [MEM_ADDR_WIDTH-1:0]   base_reg, base_next;
  logic [7:0]                  len_reg, len_next;
  logic [7:0]                  cnt_reg, cnt_next;
  logic                        err_reg, err_next;
  logic                        take_aw;
  logic                        last_beat;

  // Inputs the controller accepts but has no use for (full-width INCR only).
  logic unused_inputs;
  assign unused_inputs = ^{axi.AWSIZE, axi.AWLOCK, axi.AWCACHE, axi.AWPROT,
                           axi.AWREGION, axi.AWQOS, axi.WUSER, MEM_Q_i,
                           axi.AWADDR, axi.WLAST, axi.AWBURST};

  assign last_beat = (cnt_reg == len_reg);

  // State and transaction registers; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      id_reg    <= '0;
      user_reg  <= '0;
      base_reg  <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      id_reg    <= id_next;
      user_reg  <= user_next;
      base_reg  <= base_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  // Next-state, register updates and all outputs.
  always_comb begin
    state_next  = state_reg;
    id_next     = id_reg;
    user_next   = user_reg;
    base_next   = base_reg;
    len_next    = len_reg;
    cnt_next    = cnt_reg;
    err_next    = err_reg;
    take_aw     = 1'b0;

    axi.AWREADY = 1'b0;
    axi.WREADY  = 1'b0;
    axi.BVALID  = 1'b0;
    axi.BRESP   = 2'b00;
    axi.BID     = '0;
    axi.BUSER   = '0;
    MEM_CEN_o   = 1'b1;
    MEM_WEN_o   = 1'b1;
    MEM_A_o     = '0;
    MEM_D_o     = '0;
    MEM_BE_o    = '0;
    valid_o     = 1'b0;

    case (state_reg)
      IDLE: begin
        axi.AWREADY = 1'b1;
        take_aw     = axi.AWVALID;
      end
      DATA: begin
        valid_o    = axi.WVALID;
        MEM_CEN_o  = ~axi.WVALID;
        MEM_WEN_o  = ~axi.WVALID;
        MEM_A_o    = base_reg + MEM_ADDR_WIDTH'(cnt_reg);
        MEM_D_o    = axi.WDATA;
        MEM_BE_o   = axi.WSTRB;
        axi.WREADY = grant_i;
        if (axi.WVALID && grant_i) begin
`ifdef AXI_WRITE_ERR_CHECK_EN
          if (axi.WLAST != last_beat) err_next = 1'b1;
`endif
          if (last_beat) state_next = RESP;
          else           cnt_next   = cnt_reg + 8'd1;
        end
      end
      RESP: begin
        axi.BVALID  = 1'b1;
        axi.BID     = id_reg;
        axi.BUSER   = user_reg;
        axi.BRESP   = err_reg ? 2'b10 : 2'b00;
        axi.AWREADY = axi.BREADY;
        if (axi.BREADY) begin
          state_next = IDLE;
          take_aw    = axi.AWVALID;
        end
      end
      default: state_next = IDLE;
    endcase

    if (take_aw) begin
      state_next = DATA;
      id_next    = axi.AWID;
      user_next  = axi.AWUSER;
      base_next  = axi.AWADDR[MEM_ADDR_WIDTH+OFFSET_BIT-1:OFFSET_BIT];
      len_next   = axi.AWLEN;
      cnt_next   = 8'd0;
`ifdef AXI_WRITE_ERR_CHECK_EN
      err_next   = (axi.AWBURST == 2'b10);
`else
      err_next   = 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_axi_write_only_ctrl.sv
// Directed bench for axi_write_only_ctrl; inputs change and outputs are
// checked on the falling edge, the DUT samples on the rising edge.
module tb_axi_write_only_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_cen, mem_wen, grant, valid;
  logic [12:0] mem_a;
  logic [63:0] mem_d, mem_q;
  logic [7:0]  mem_be;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [12:0] wr_log [0:63];

`ifdef AXI_WRITE_ERR_CHECK_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  axi_write_only_ctrl_if #(.ADDR_W(32), .DATA_W(64), .ID_W(16), .USER_W(10)) axi ();

  axi_write_only_ctrl dut (
    .clk(clk), .rst(rst), .axi(axi.slave),
    .MEM_CEN_o(mem_cen), .MEM_WEN_o(mem_wen), .MEM_A_o(mem_a),
    .MEM_D_o(mem_d), .MEM_BE_o(mem_be), .MEM_Q_i(mem_q),
    .grant_i(grant), .valid_o(valid)
  );

  always #5 clk = ~clk;

  // Log every write the memory would actually perform.
  always @(posedge clk) begin
    if (!mem_cen && !mem_wen && grant) begin
      wr_log[wr_cnt] <= mem_a;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic aw(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len);
    axi.AWVALID = 1'b1; axi.AWID = id; axi.AWADDR = addr; axi.AWLEN = len;
    axi.AWUSER = id[9:0];
  endtask

  task automatic wbeat(input logic [63:0] d, input logic last, input logic g);
    axi.WVALID = 1'b1; axi.WDATA = d; axi.WSTRB = 8'hFF; axi.WLAST = last;
    grant = g;
  endtask

  initial begin
    int base_cnt;
    rst = 1'b1; grant = 1'b0; mem_q = '0;
    axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = 3'd3;
    axi.AWBURST = 2'b01; axi.AWLOCK = 1'b0; axi.AWCACHE = '0; axi.AWPROT = '0;
    axi.AWREGION = '0; axi.AWUSER = '0; axi.AWQOS = '0; axi.AWVALID = 1'b0;
    axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0; axi.WUSER = '0;
    axi.WVALID = 1'b0; axi.BREADY = 1'b0;
    tick(); tick();
    rst = 1'b0; settle();
    chk("rst_awready", axi.AWREADY, 1);
    chk("rst_wready", axi.WREADY, 0);
    chk("rst_bvalid", axi.BVALID, 0);
    chk("rst_cen", mem_cen, 1);
    chk("rst_wen", mem_wen, 1);
    chk("rst_valid", valid, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_bid", axi.BID, 0);
    $display("reset checked");

    // Single write
    tick(); aw(16'h1234, 32'h40, 8'd0); settle();
    chk("single_aw_awready", axi.AWREADY, 1);
    chk("single_aw_no_mem", mem_cen, 1);
    tick(); axi.AWVALID = 1'b0; wbeat(64'hDEADBEEF_CAFEF00D, 1'b1, 1'b1); settle();
    chk("single_mem_a", mem_a, 13'h8);
    chk("single_wen", mem_wen, 0);
    chk("single_cen", mem_cen, 0);
    chk("single_be", mem_be, 8'hFF);
    chk("single_d", mem_d, 64'hDEADBEEF_CAFEF00D);
    chk("single_wready", axi.WREADY, 1);
    chk("single_valid", valid, 1);
    tick(); axi.WVALID = 1'b0; axi.BREADY = 1'b1; settle();
    chk("single_bvalid", axi.BVALID, 1);
    chk("single_bresp", axi.BRESP, 2'b00);
    chk("single_bid", axi.BID, 16'h1234);
    chk("single_no_mem_resp", mem_cen, 1);
    tick(); axi.BREADY = 1'b0; settle();
    chk("single_idle_bvalid", axi.BVALID, 0);
    chk("single_wr_cnt", wr_cnt, 1);
    chk("single_wr_addr", wr_log[0], 13'h8);
    $display("single write done, writes=%0d", wr_cnt);

    // Burst of 4 with grant stalls on beats 1 and 2
    tick(); aw(16'h0042, 32'h100, 8'd3); settle();
    tick(); axi.AWVALID = 1'b0; wbeat(64'h0, 1'b0, 1'b1); settle();
    chk("burst_b0_a", mem_a, 13'h20);
    for (int b = 1; b <= 2; b++) begin
      for (int s = 0; s < 2; s++) begin
        tick(); wbeat(64'(b), 1'b0, 1'b0); settle();
        chk("burst_stall_wready", axi.WREADY, 0);
        chk("burst_stall_a", mem_a, 13'(32 + b));
      end
      tick(); wbeat(64'(b), 1'b0, 1'b1); settle();
      chk("burst_go_a", mem_a, 13'(32 + b));
      chk("burst_go_wready", axi.WREADY, 1);
    end
    tick(); wbeat(64'h3, 1'b1, 1'b1); settle();
    chk("burst_b3_a", mem_a, 13'h23);
    tick(); axi.WVALID = 1'b0; axi.BREADY = 1'b1; settle();
    chk("burst_bvalid", axi.BVALID, 1);
    chk("burst_bid", axi.BID, 16'h0042);
    chk("burst_wr_cnt", wr_cnt, 5);
    for (int i = 0; i < 4; i++) chk("burst_wr_addr", wr_log[1 + i], 13'(32 + i));
    tick(); axi.BREADY = 1'b0; settle();
    $display("burst with stalls done, writes=%0d", wr_cnt);

    // B backpressure, then back-to-back AW that wraps the word address
    tick(); aw(16'hAAAA, 32'h8, 8'd0); settle();
    tick(); axi.AWVALID = 1'b0; wbeat(64'h55, 1'b1, 1'b1); settle();
    tick(); axi.WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_bvalid_held", axi.BVALID, 1);
      chk("bp_bid_stable", axi.BID, 16'hAAAA);
      chk("bp_awready_low", axi.AWREADY, 0);
      tick();
    end
    axi.BREADY = 1'b1; aw(16'h5555, 32'hFFF8, 8'd1); settle();
    chk("bp_release_bvalid", axi.BVALID, 1);
    chk("bp_release_awready", axi.AWREADY, 1);
    tick(); axi.AWVALID = 1'b0; axi.BREADY = 1'b0; wbeat(64'h1, 1'b0, 1'b1); settle();
    chk("wrap_b0_a", mem_a, 13'h1FFF);
    chk("wrap_b0_wen", mem_wen, 0);
    tick(); wbeat(64'h2, 1'b1, 1'b1); settle();
    chk("wrap_b1_a", mem_a, 13'h0000);
    tick(); axi.WVALID = 1'b0; axi.BREADY = 1'b1; settle();
    chk("wrap_bid", axi.BID, 16'h5555);
    chk("wrap_bresp", axi.BRESP, 2'b00);
    chk("wrap_wr_cnt", wr_cnt, 8);
    chk("wrap_log0", wr_log[6], 13'h1FFF);
    chk("wrap_log1", wr_log[7], 13'h0000);
    tick(); axi.BREADY = 1'b0;
    $display("backpressure and wrap done, writes=%0d", wr_cnt);

    // WLAST on beat 1 of a 3-beat burst
    tick(); aw(16'h0777, 32'h200, 8'd2); settle();
    tick(); axi.AWVALID = 1'b0; wbeat(64'hA, 1'b0, 1'b1); settle();
    chk("err_b0_a", mem_a, 13'h40);
    tick(); wbeat(64'hB, 1'b1, 1'b1); settle();
    tick(); wbeat(64'hC, 1'b0, 1'b1); settle();
    chk("err_b2_a", mem_a, 13'h42);
    tick(); axi.WVALID = 1'b0; axi.BREADY = 1'b1; settle();
    chk("err_bvalid", axi.BVALID, 1);
    chk("err_bresp", axi.BRESP, ERR_RESP);
    chk("err_wr_cnt", wr_cnt, 11);
    tick(); axi.BREADY = 1'b0;
    $display("wlast mismatch burst done, bresp=%0d", ERR_RESP);

    // Reset after 2 of 4 beats
    tick(); aw(16'h0999, 32'h300, 8'd3); settle();
    tick(); axi.AWVALID = 1'b0; wbeat(64'h1, 1'b0, 1'b1); settle();
    tick(); wbeat(64'h2, 1'b0, 1'b1); settle();
    chk("rstm_b1_a", mem_a, 13'h61);
    tick(); axi.WVALID = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0; settle();
    chk("rstm_awready", axi.AWREADY, 1);
    chk("rstm_wready", axi.WREADY, 0);
    base_cnt = wr_cnt;
    chk("rstm_wr_cnt", base_cnt, 13);
    axi.BREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wbeat(64'hF, 1'b0, 1'b1); settle();
      chk("rstm_bvalid_never", axi.BVALID, 0);
      chk("rstm_cen_idle", mem_cen, 1);
      tick();
    end
    chk("rstm_no_more_writes", wr_cnt, base_cnt);
    $display("reset mid-burst done, writes=%0d", wr_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
